// File: rtl/rv32_irq_ctrl.sv
// Interrupt controller plus machine timer: per-source pending/enable/priority, claim/complete, 64-bit mtime/mtimecmp.
// Latency: bus_rdata one cycle after bus_rstrb; meip one cycle after a source becomes eligible; mtip registered compare.
// Backpressure: none; every strobe completes in its cycle, read data holds until the next read.
module rv32_irq_ctrl #(
  parameter int                 NUM_SRC   = 8,
  parameter int                 PRIO_BITS = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
  parameter int                 TICK_DIV  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_wstrb,
  input  logic               bus_rstrb,
  output logic [31:0]        bus_rdata,
  output logic               meip,
  output logic               mtip
);

  // Word addresses (byte address >> 2)
  localparam logic [5:0] W_PEND  = 6'h00;
  localparam logic [5:0] W_EN    = 6'h01;
  localparam logic [5:0] W_THR   = 6'h02;
  localparam logic [5:0] W_CLAIM = 6'h03;
  localparam logic [5:0] W_MLO   = 6'h04;
  localparam logic [5:0] W_MHI   = 6'h05;
  localparam logic [5:0] W_CLO   = 6'h06;
  localparam logic [5:0] W_CHI   = 6'h07;
  localparam logic [5:0] W_PRIO0 = 6'h10;
  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [NUM_SRC-1:0]                pending_q, pending_d;
  logic [NUM_SRC-1:0]                in_service_q, in_service_d;
  logic [NUM_SRC-1:0]                enable_q, enable_d;
  logic [NUM_SRC-1:0]                irq_prev_q, irq_prev_d;
  logic [PRIO_BITS-1:0]              threshold_q, threshold_d;
  logic [NUM_SRC-1:0][PRIO_BITS-1:0] prio_q, prio_d;
  logic [63:0]                       mtime_q, mtime_d;
  logic [63:0]                       mtimecmp_q, mtimecmp_d;
  logic [15:0]                       presc_q, presc_d;
  logic [31:0]                       rdata_q, rdata_d;
  logic                              meip_q, meip_d;
  logic                              mtip_q, mtip_d;

  logic [5:0]           word;
  logic [5:0]           prio_off;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   win_oh;
  logic [NUM_SRC-1:0]   set_vec;
  logic [PRIO_BITS-1:0] win_prio;
  logic [4:0]           win_id;
  logic                 win_found;
  logic                 claim;
  logic [31:0]          rd_val;
  logic                 unused_addr_bits;

  assign word             = bus_addr[7:2];
  assign prio_off         = word - W_PRIO0;
  assign unused_addr_bits = ^bus_addr[1:0];

  // Arbitration: highest priority among eligible sources; strict '>' keeps ties on the lowest index
  always_comb begin
    elig      = '0;
    win_oh    = '0;
    win_prio  = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
      if (elig[i] && (!win_found || (prio_q[i] > win_prio))) begin
        win_found = 1'b1;
        win_prio  = prio_q[i];
        win_id    = 5'(i + 1);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Read mux; values are pre-write state, so a simultaneous write returns the old contents
  always_comb begin
    rd_val = '0;
    case (word)
      W_PEND:  rd_val = 32'(pending_q);
      W_EN:    rd_val = 32'(enable_q);
      W_THR:   rd_val = 32'(threshold_q);
      W_CLAIM: rd_val = 32'(win_id);
      W_MLO:   rd_val = mtime_q[31:0];
      W_MHI:   rd_val = mtime_q[63:32];
      W_CLO:   rd_val = mtimecmp_q[31:0];
      W_CHI:   rd_val = mtimecmp_q[63:32];
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if ((word >= W_PRIO0) && (prio_off == 6'(i))) rd_val = 32'(prio_q[i]);
        end
      end
    endcase
  end

  // Next-state: pending/in-service bookkeeping, register writes, timer and output registers
  always_comb begin
    irq_prev_d  = irq_src;
    set_vec     = (EDGE_MASK & irq_src & ~irq_prev_q) | (~EDGE_MASK & irq_src);
    claim       = bus_rstrb && (word == W_CLAIM) && win_found;
    // Sources in service cannot re-pend; a claim in the same cycle wins over a new set
    pending_d    = pending_q | (set_vec & ~in_service_q);
    in_service_d = in_service_q;
    if (claim) begin
      pending_d    = pending_d & ~win_oh;
      in_service_d = in_service_d | win_oh;
    end
    enable_d    = enable_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    mtimecmp_d  = mtimecmp_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      mtime_d = mtime_q;
    end
    if (bus_wstrb) begin
      case (word)
        W_EN:    enable_d    = bus_wdata[NUM_SRC-1:0];
        W_THR:   threshold_d = bus_wdata[PRIO_BITS-1:0];
        W_CLAIM: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if ((bus_wdata == 32'(i + 1)) && in_service_q[i]) in_service_d[i] = 1'b0;
          end
        end
        // An mtime write restarts the prescaler and replaces the tick of this cycle
        W_MLO: begin
          mtime_d = {mtime_q[63:32], bus_wdata};
          presc_d = '0;
        end
        W_MHI: begin
          mtime_d = {bus_wdata, mtime_q[31:0]};
          presc_d = '0;
        end
        W_CLO:   mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
        W_CHI:   mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if ((word >= W_PRIO0) && (prio_off == 6'(i))) prio_d[i] = bus_wdata[PRIO_BITS-1:0];
          end
        end
      endcase
    end
    rdata_d = bus_rstrb ? rd_val : rdata_q;
    meip_d  = |elig;
    mtip_d  = (mtime_q >= mtimecmp_q);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      irq_prev_q   <= '0;
      threshold_q  <= '0;
      prio_q       <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      presc_q      <= '0;
      rdata_q      <= '0;
      meip_q       <= 1'b0;
      mtip_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      irq_prev_q   <= irq_prev_d;
      threshold_q  <= threshold_d;
      prio_q       <= prio_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      presc_q      <= presc_d;
      rdata_q      <= rdata_d;
      meip_q       <= meip_d;
      mtip_q       <= mtip_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign meip      = meip_q;
  assign mtip      = mtip_q;

endmodule

// File: tb/tb_rv32_irq_ctrl.sv
// Bench for rv32_irq_ctrl: directed scenarios plus randomized priority/claim sequences against a reference model.
// Latency: reads are observed on the negedge after the strobe edge.
// Backpressure: none; the bus tasks issue one strobe per call.
module tb_rv32_irq_ctrl;
  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wstrb;
  logic        bus_rstrb;
  logic [31:0] bus_rdata;
  logic        meip;
  logic        mtip;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model of the software-visible configuration
  logic [2:0] m_prio [8];
  logic [7:0] m_en;
  logic [2:0] m_thr;

  rv32_irq_ctrl #(.NUM_SRC(8), .PRIO_BITS(3), .EDGE_MASK(8'h02), .TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rstrb(bus_rstrb), .bus_rdata(bus_rdata), .meip(meip), .mtip(mtip)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Winner by definition: find the top eligible priority, then the first source holding it
  function automatic int model_winner(input logic [7:0] pend);
    int best = -1;
    for (int i = 0; i < 8; i++)
      if (pend[i] && m_en[i] && (m_prio[i] > m_thr) && (int'(m_prio[i]) > best)) best = int'(m_prio[i]);
    if (best < 0) return 0;
    for (int i = 0; i < 8; i++)
      if (pend[i] && m_en[i] && (int'(m_prio[i]) == best)) return i + 1;
    return 0;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wstrb = 1'b1;
    @(negedge clk);
    bus_wstrb = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_rstrb = 1'b1;
    @(negedge clk);
    bus_rstrb = 1'b0;
    d = bus_rdata;
  endtask

  task automatic set_prio(input int i, input logic [2:0] p);
    bus_write(8'h40 + 8'(4 * i), 32'(p));
    m_prio[i] = p;
  endtask

  task automatic set_en(input logic [7:0] e);
    bus_write(8'h04, 32'(e));
    m_en = e;
  endtask

  task automatic set_thr(input logic [2:0] t);
    bus_write(8'h08, 32'(t));
    m_thr = t;
  endtask

  // Return the controller to "nothing pending, nothing in service"
  task automatic drain();
    logic [31:0] id;
    irq_src = '0;
    for (int k = 1; k <= 8; k++) bus_write(8'h0C, 32'(k));
    for (int i = 0; i < 8; i++) set_prio(i, 3'd1);
    set_en(8'hFF);
    set_thr(3'd0);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      bus_read(8'h0C, id);
      if (id == 0) break;
      bus_write(8'h0C, id);
    end
  endtask

  task automatic test_reset();
    logic [7:0]  addr_tab [9];
    logic [31:0] exp_tab  [9];
    logic [31:0] rd;
    int rel;
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h5C};
    exp_tab  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL reset_meip got=%b exp=0", meip); end
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL reset_mtip got=%b exp=0", mtip); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus_rdata); end
    rst = 1'b1;
    rel = cyc;
    for (int k = 0; k < 9; k++) begin
      bus_read(addr_tab[k], rd);
      checks++;
      if (rd !== exp_tab[k]) begin errors++; $display("FAIL reset_reg addr=%h got=%h exp=%h", addr_tab[k], rd, exp_tab[k]); end
    end
    bus_read(8'h10, rd);
    checks++;
    if (rd !== 32'((cyc - 1 - rel) / TICK)) begin
      errors++; $display("FAIL reset_mtime_lo got=%h exp=%h", rd, 32'((cyc - 1 - rel) / TICK));
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    set_en(8'hA5);
    bus_read(8'h06, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL en_lowbits_ignored got=%h exp=a5", rd); end
    bus_write(8'h04, 32'hFFFF_FF5A); m_en = 8'h5A;
    bus_read(8'h04, rd);
    checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL en_width got=%h exp=5a", rd); end
    bus_write(8'h4C, 32'hFFFF_FFFF); m_prio[3] = 3'd7;
    bus_read(8'h4C, rd);
    checks++; if (rd !== 32'h7) begin errors++; $display("FAIL prio_width got=%h exp=7", rd); end
    bus_write(8'h20, 32'h1234);
    bus_read(8'h20, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_20 got=%h exp=0", rd); end
    bus_write(8'h60, 32'h7);
    bus_read(8'h60, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_60 got=%h exp=0", rd); end
    set_thr(3'd2);
    @(negedge clk);
    bus_addr = 8'h08; bus_wdata = 32'h5; bus_wstrb = 1'b1; bus_rstrb = 1'b1;
    @(negedge clk);
    bus_wstrb = 1'b0; bus_rstrb = 1'b0; m_thr = 3'd5;
    rd = bus_rdata;
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL rw_same_cycle got=%h exp=2", rd); end
    bus_write(8'h04, 32'h0); m_en = 8'h00;
    checks++; if (bus_rdata !== 32'h2) begin errors++; $display("FAIL rdata_hold got=%h exp=2", bus_rdata); end
    bus_read(8'h08, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL thr_after_rw got=%h exp=5", rd); end
  endtask

  task automatic test_level_prio();
    logic [31:0] rd;
    drain();
    for (int i = 0; i < 8; i++) set_prio(i, 3'd0);
    set_prio(2, 3'd3); set_prio(5, 3'd3); set_prio(6, 3'd5);
    irq_src = 8'h64;
    repeat (2) @(negedge clk);
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd7) begin errors++; $display("FAIL level_claim1 got=%0d exp=7", rd); end
    irq_src[6] = 1'b0;
    bus_write(8'h0C, 32'd7);
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL level_claim2 got=%0d exp=3", rd); end
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd6) begin errors++; $display("FAIL level_claim3 got=%0d exp=6", rd); end
  endtask

  task automatic test_threshold();
    drain();
    for (int i = 0; i < 8; i++) set_prio(i, 3'd0);
    set_prio(0, 3'd2);
    set_en(8'h01);
    set_thr(3'd2);
    irq_src = 8'h01;
    repeat (3) @(negedge clk);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL thr_equal_meip got=%b exp=0", meip); end
    bus_write(8'h08, 32'd1); m_thr = 3'd1;
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL thr_meip_early got=%b exp=0", meip); end
    @(negedge clk);
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL thr_meip_rise got=%b exp=1", meip); end
  endtask

  task automatic pulse_src1();
    @(negedge clk); irq_src[1] = 1'b1;
    @(negedge clk); irq_src[1] = 1'b0;
  endtask

  task automatic test_edge();
    logic [31:0] rd;
    drain();
    set_en(8'h02);
    pulse_src1();
    bus_read(8'h00, rd);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL edge_pend1 got=%h exp=02", rd); end
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL edge_claim got=%0d exp=2", rd); end
    pulse_src1();
    bus_read(8'h00, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL edge_dropped got=%h exp=00", rd); end
    bus_write(8'h0C, 32'd2);
    pulse_src1();
    bus_read(8'h00, rd);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL edge_repend got=%h exp=02", rd); end
  endtask

  task automatic test_bogus();
    logic [31:0] rd;
    drain();
    set_en(8'h08);
    irq_src = 8'h08;
    repeat (2) @(negedge clk);
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL bogus_claim got=%0d exp=4", rd); end
    bus_write(8'h0C, 32'd9);
    bus_write(8'h0C, 32'd0);
    bus_write(8'h0C, 32'd3);
    bus_write(8'h0C, 32'h104);
    repeat (2) @(negedge clk);
    bus_read(8'h00, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bogus_still_in_service got=%h exp=0", rd); end
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL bogus_empty_claim got=%0d exp=0", rd); end
    bus_read(8'h04, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL bogus_enable got=%h exp=08", rd); end
    bus_write(8'h0C, 32'd4);
    repeat (2) @(negedge clk);
    bus_read(8'h00, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL level_repend got=%h exp=08", rd); end
    irq_src = 8'h00;
  endtask

  task automatic test_timer();
    logic [31:0] rd;
    logic [63:0] expm;
    int c0, n, exp_n;
    bit seen;
    bus_write(8'h1C, 32'd0);
    bus_write(8'h18, 32'd10);
    bus_write(8'h14, 32'd0);
    bus_write(8'h10, 32'd0);
    c0 = cyc;
    exp_n = 1;
    while (((exp_n - 1) / TICK) < 10) exp_n++;
    seen = 1'b0; n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mtip === 1'b1) begin seen = 1'b1; n = cyc - c0; break; end
    end
    checks++;
    if (!seen || (n != exp_n)) begin errors++; $display("FAIL mtip_rise cycles got=%0d seen=%0b exp=%0d", n, seen, exp_n); end
    bus_read(8'h10, rd);
    expm = 64'((cyc - 1 - c0) / TICK);
    checks++; if (rd !== expm[31:0]) begin errors++; $display("FAIL mtime_count got=%h exp=%h", rd, expm[31:0]); end
    bus_write(8'h14, 32'd0);
    bus_write(8'h10, 32'hFFFF_FFFF);
    c0 = cyc;
    repeat (TICK - 1) @(negedge clk);
    bus_read(8'h10, rd);
    expm = 64'hFFFF_FFFF + 64'((cyc - 1 - c0) / TICK);
    checks++; if (rd !== expm[31:0]) begin errors++; $display("FAIL wrap_lo got=%h exp=%h", rd, expm[31:0]); end
    bus_read(8'h14, rd);
    expm = 64'hFFFF_FFFF + 64'((cyc - 1 - c0) / TICK);
    checks++; if (rd !== expm[63:32]) begin errors++; $display("FAIL wrap_hi got=%h exp=%h", rd, expm[63:32]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [7:0]  pend;
      logic [31:0] rd;
      int          exp_id;
      drain();
      for (int i = 0; i < 8; i++) set_prio(i, 3'($urandom_range(0, 7)));
      set_en(8'($urandom));
      set_thr(3'($urandom_range(0, 6)));
      pend = 8'($urandom) & 8'hFD;
      irq_src = pend;
      repeat (2) @(negedge clk);
      checks++;
      if (meip !== (model_winner(pend) != 0)) begin
        errors++; $display("FAIL rand_meip it=%0d got=%b exp=%b", it, meip, (model_winner(pend) != 0));
      end
      bus_read(8'h00, rd);
      checks++; if (rd !== 32'(pend)) begin errors++; $display("FAIL rand_pending it=%0d got=%h exp=%h", it, rd, pend); end
      for (int n = 0; n < 9; n++) begin
        exp_id = model_winner(pend);
        bus_read(8'h0C, rd);
        checks++;
        if (rd !== 32'(exp_id)) begin errors++; $display("FAIL rand_claim it=%0d step=%0d got=%0d exp=%0d", it, n, rd, exp_id); end
        if (exp_id == 0) break;
        pend[exp_id - 1] = 1'b0;
      end
      irq_src = '0;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [7:0]  addr_tab [7];
    logic [31:0] exp_tab  [7];
    int rel;
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h14, 8'h18, 8'h1C};
    exp_tab  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    drain();
    set_en(8'h05);
    irq_src = 8'h05;
    repeat (2) @(negedge clk);
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL mid_claim got=%0d exp=1", rd); end
    bus_write(8'h14, 32'd0);
    bus_write(8'h10, 32'h1234);
    repeat (3) @(negedge clk);
    checks++; if ((meip !== 1'b1) || (mtip !== 1'b1)) begin errors++; $display("FAIL mid_pre meip=%b mtip=%b exp=1,1", meip, mtip); end
    irq_src = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL mid_meip got=%b exp=0", meip); end
    checks++; if (mtip !== 1'b0) begin errors++; $display("FAIL mid_mtip got=%b exp=0", mtip); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata got=%h exp=0", bus_rdata); end
    #3;
    rst = 1'b1;
    rel = cyc;
    for (int i = 0; i < 8; i++) m_prio[i] = 3'd0;
    m_en = 8'h00; m_thr = 3'd0;
    for (int k = 0; k < 7; k++) begin
      bus_read(addr_tab[k], rd);
      checks++;
      if (rd !== exp_tab[k]) begin errors++; $display("FAIL mid_reg addr=%h got=%h exp=%h", addr_tab[k], rd, exp_tab[k]); end
    end
    bus_read(8'h10, rd);
    checks++;
    if (rd !== 32'((cyc - 1 - rel) / TICK)) begin
      errors++; $display("FAIL mid_mtime_lo got=%h exp=%h", rd, 32'((cyc - 1 - rel) / TICK));
    end
    set_prio(0, 3'd1);
    set_en(8'h01);
    irq_src = 8'h01;
    repeat (2) @(negedge clk);
    bus_read(8'h0C, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL mid_in_service_cleared got=%0d exp=1", rd); end
    irq_src = 8'h00;
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1; irq_src = '0; bus_addr = '0; bus_wdata = '0; bus_wstrb = 1'b0; bus_rstrb = 1'b0;
    for (int i = 0; i < 8; i++) m_prio[i] = 3'd0;
    m_en = 8'h00; m_thr = 3'd0;
    #2 rst = 1'b0;
    test_reset();
    test_regs();
    test_level_prio();
    test_threshold();
    test_edge();
    test_bogus();
    test_timer();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_irq_ctrl.md
RV32_IRQ_CTRL -- requirements
Module: rv32_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of external interrupt sources (legal range 1..31).
REQ-002 SHALL have parameter PRIO_BITS, default 3, width of each per-source priority and of the threshold.
REQ-003 SHALL have parameter EDGE_MASK, default 0, NUM_SRC-bit mask; bit i=1 makes source i edge-triggered (rising edge), 0 makes it level-triggered.
REQ-004 SHALL have parameter TICK_DIV, default 1, number of clk cycles per mtime increment (legal range 1..65535).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-007 SHALL have port irq_src, input, NUM_SRC, interrupt request lines, already synchronous to clk.
REQ-008 SHALL have port bus_addr, input, 8, register byte address; bits [1:0] are ignored.
REQ-009 SHALL have port bus_wdata, input, 32, write data.
REQ-010 SHALL have port bus_wstrb, input, 1, one-cycle write strobe.
REQ-011 SHALL have port bus_rstrb, input, 1, one-cycle read strobe.
REQ-012 SHALL have port bus_rdata, output, 32, read data.
REQ-013 SHALL have port meip, output, 1, external interrupt pending, for the core's mip.MEIP.
REQ-014 SHALL have port mtip, output, 1, timer interrupt pending, for the core's mip.MTIP.

Function
REQ-015 SHALL decode this register map, with all others reading 0 and ignoring writes: 0x00 PENDING (RO); 0x04 ENABLE (RW); 0x08 THRESHOLD (RW, PRIO_BITS LSBs); 0x0C CLAIM (read) / COMPLETE (write); 0x10 MTIME_LO; 0x14 MTIME_HI; 0x18 MTIMECMP_LO; 0x1C MTIMECMP_HI; 0x40+4*i PRIORITY[i] (RW, PRIO_BITS LSBs).
REQ-016 SHALL return bus_rdata exactly one cycle after bus_rstrb and hold it until the next read; there is no busy signal.
REQ-017 SHALL use a registered copy of irq_src for edge detection; an edge is prev=0 and cur=1.
REQ-018 SHALL set pending[i] on a rising edge (edge source) or while irq_src[i]=1 (level source), but only when in_service[i]=0; edges arriving while in service are dropped.
REQ-019 SHALL define source i as eligible when pending[i] & enable[i] & (priority[i] > threshold).
REQ-020 SHALL select the winner as the eligible source with the highest priority, ties going to the lowest index; winner ID = index+1, and ID 0 means no eligible source.
REQ-021 SHALL drive meip as a registered value, high one cycle after any source becomes eligible.
REQ-022 SHALL, on a CLAIM read, return the current winner ID, clear that source's pending bit and set its in_service bit in the same cycle; a claim returning 0 changes no state.
REQ-023 SHALL, on a COMPLETE write of ID k (1..NUM_SRC) with in_service[k-1]=1, clear in_service[k-1]; any other ID is ignored.
REQ-024 SHALL let a level source that is still high re-pend in the cycle after COMPLETE.
REQ-025 SHALL give a pending set and a claim-clear of the same source in the same cycle to the claim (pending ends at 0).
REQ-026 SHALL implement a 64-bit mtime counter incremented once every TICK_DIV cycles (prescaler counts 0..TICK_DIV-1), wrapping from 2^64-1 to 0.
REQ-027 SHALL, on a write to MTIME_LO or MTIME_HI, replace only that half, reset the prescaler to 0, and suppress the increment in that cycle.
REQ-028 SHALL drive mtip as a registered (mtime >= mtimecmp, unsigned 64-bit) value, updated every cycle.
REQ-029 SHALL, when bus_wstrb and bus_rstrb are both asserted, perform the write and return the pre-write register value.

Reset
REQ-030 SHALL, while rst=0, asynchronously force: pending, in_service, enable, threshold, all priorities, mtime and the prescaler to 0; mtimecmp to all-ones; bus_rdata, meip and mtip to 0; irq_src history to 0.
REQ-031 SHALL, when rst is asserted in the middle of a claim or a timer count, abandon it with no residual state; the first edge after rst rises is the first active edge.

Verification
REQ-032 SHALL verify level priority: NUM_SRC=8; PRIORITY[2]=3, PRIORITY[5]=3, PRIORITY[6]=5, ENABLE=0xFF, THRESHOLD=0, irq_src=0x64 -> CLAIM reads 7, then (after COMPLETE 7 with src6 low) 3, then 6.
REQ-033 SHALL verify threshold: PRIORITY[0]=2, THRESHOLD=2, src0 high -> meip stays 0; THRESHOLD=1 -> meip=1 one cycle later.
REQ-034 SHALL verify edge source: EDGE_MASK bit1=1; pulse src1, claim (reads 2), pulse src1 again before COMPLETE -> PENDING bit1 stays 0; after COMPLETE 2, a new pulse sets it.
REQ-035 SHALL verify the timer: TICK_DIV=4; MTIMECMP=10, MTIME=0 -> mtip rises 41 cycles after the MTIME write; at MTIME_LO=0xFFFFFFFF with HI=0, one tick later reads LO=0, HI=1.
REQ-036 SHALL verify bogus complete: COMPLETE 9 and COMPLETE of a source not in service -> no state change; a CLAIM with nothing eligible reads 0.
REQ-037 SHALL verify reset: assert rst=0 for one half-cycle while a source is in service and mtime=0x1234 -> all registers read reset values, meip=mtip=0.
